// File: rtl/muldiv_arbiter_pkg.sv
// Shared types and constants for the multiply/divide arbiter slice.
//   op_e             : command opcode (MUL / DIV)
//   state_e          : arbiter FSM state encoding
//   MIN_START_CYCLES : minimum number of cycles a unit start is held
package muldiv_arb_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int MIN_START_CYCLES = 2;

endpackage

// File: rtl/muldiv_arbiter_if.sv
// Requester/response bus of the multiply/divide arbiter.
//   req_valid/req_ready : per-requester command handshake
//   req_op/req_a/req_b  : per-requester command fields
//   rsp_*               : single response channel back to the requesters
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both 1. The producer holds valid and its
// payload stable until that edge; ready may depend combinationally on valid.
// master = requester side, slave = arbiter side.
interface muldiv_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_op;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic                          rsp_op;
  logic [2*WIDTH-1:0]            rsp_data;
  logic                          rsp_dz;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_op, rsp_data, rsp_dz
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_op, rsp_data, rsp_dz
  );
endinterface

// File: rtl/muldiv_arbiter_rr.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : encoded grant index (0 when no request)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   j;

  // Scan N positions starting at ptr, wrapping; first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one sequential multiplier and one restoring divider between
// NUM_REQ requesters, one operation outstanding at a time.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus               : requester commands and response channel (slave side)
//   mul_start/div_start, mul_a/mul_b, div_dividend/div_divisor : unit drive
//   mul_prod, div_quotient, div_remainder, mul_ready, div_ready : unit results
//   fsm_state         : current FSM state (debug observation)
module muldiv_arbiter
  import muldiv_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_arbiter_if.slave    bus,
  output logic               mul_start,
  output logic               div_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic [2*WIDTH-1:0] mul_prod,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder,
  input  logic               mul_ready,
  input  logic               div_ready,
  output state_e             fsm_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] ISSUE_LAST = 2'(MIN_START_CYCLES - 1);

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  op_e                op_q;
  logic [IW-1:0]      id_q;
  logic [1:0]         issue_cnt;
  logic               rsp_valid_q;
  logic               rsp_dz_q;
  logic [2*WIDTH-1:0] rsp_data_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               any_req;
  logic               sel_ready;
  logic [IW-1:0]      ptr_next;
  logic [WIDTH-1:0]   gnt_a;
  logic [WIDTH-1:0]   gnt_b;
  op_e                gnt_op;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_req   = |bus.req_valid;
  assign gnt_a     = bus.req_a[gnt_idx];
  assign gnt_b     = bus.req_b[gnt_idx];
  assign gnt_op    = op_e'(bus.req_op[gnt_idx]);
  assign ptr_next  = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign sel_ready = (op_q == OP_DIV) ? div_ready : mul_ready;

  // Grant is only visible while idle; any other state blocks all requesters.
  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_op    = op_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_dz    = rsp_dz_q;
  assign fsm_state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      op_q         <= OP_MUL;
      id_q         <= '0;
      issue_cnt    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dz_q     <= 1'b0;
      rsp_data_q   <= '0;
      mul_start    <= 1'b0;
      div_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ptr_q     <= ptr_next;
            op_q      <= gnt_op;
            id_q      <= gnt_idx;
            issue_cnt <= '0;
            if (gnt_op == OP_DIV && gnt_b == '0) begin
              // Divide-by-zero is answered locally without touching a unit.
              rsp_data_q  <= {gnt_a, {WIDTH{1'b1}}};
              rsp_dz_q    <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              rsp_dz_q <= 1'b0;
              // Operands of a unit only change when that unit is started.
              if (gnt_op == OP_DIV) begin
                div_start    <= 1'b1;
                div_dividend <= gnt_a;
                div_divisor  <= gnt_b;
              end else begin
                mul_start <= 1'b1;
                mul_a     <= gnt_a;
                mul_b     <= gnt_b;
              end
              state_q <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // Hold start for the minimum count and until the unit has
          // acknowledged by dropping ready, so a stale ready is not read
          // as completion.
          if (issue_cnt != ISSUE_LAST) begin
            issue_cnt <= issue_cnt + 2'd1;
          end else if (!sel_ready) begin
            mul_start <= 1'b0;
            div_start <= 1'b0;
            state_q   <= WAIT;
          end
        end

        WAIT: begin
          if (sel_ready) begin
            rsp_data_q  <= (op_q == OP_DIV) ? {div_remainder, div_quotient}
                                            : mul_prod;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
module tb_muldiv_arbiter;
  import muldiv_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int EW      = 2 + 1 + 1 + 2 * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT and unit models ----------------
  muldiv_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  logic               mul_start, div_start;
  logic [WIDTH-1:0]   mul_a, mul_b, div_dividend, div_divisor;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   div_quotient, div_remainder;
  logic               mul_ready, div_ready;
  state_e             fsm_state;

  muldiv_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .mul_start     (mul_start),
    .div_start     (div_start),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .mul_prod      (mul_prod),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .mul_ready     (mul_ready),
    .div_ready     (div_ready),
    .fsm_state     (fsm_state)
  );

  // Behavioural units: ready is 1 when idle, drops on start, returns after
  // a fixed compute time with the result.
  logic [3:0] mul_cnt, div_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ready <= 1'b1; mul_cnt <= '0; mul_prod <= '0;
    end else if (mul_ready && mul_start) begin
      mul_ready <= 1'b0; mul_cnt <= 4'd5; mul_prod <= mul_a * mul_b;
    end else if (!mul_ready) begin
      if (mul_cnt == 0) mul_ready <= 1'b1;
      else mul_cnt <= mul_cnt - 4'd1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ready <= 1'b1; div_cnt <= '0; div_quotient <= '0; div_remainder <= '0;
    end else if (div_ready && div_start) begin
      div_ready     <= 1'b0; div_cnt <= 4'd9;
      div_quotient  <= div_dividend / div_divisor;
      div_remainder <= div_dividend % div_divisor;
    end else if (!div_ready) begin
      if (div_cnt == 0) div_ready <= 1'b1;
      else div_cnt <= div_cnt - 4'd1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  function automatic logic [EW-1:0] exp_rsp(input logic [1:0] id, input logic op,
                                            input logic dz, input logic [31:0] data);
    return {id, op, dz, data};
  endfunction

  // Monitor: every response handshake pops one expected entry.
  task automatic monitor();
    logic [EW-1:0] got;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        got = {bus.rsp_id, bus.rsp_op, bus.rsp_dz, bus.rsp_data};
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(got), 64'(0));
        end else begin
          check("rsp", 64'(got), 64'(exp_q.pop_front()));
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  int cyc = 0, acc_cyc = 0, rv_cyc = 0;
  int mul_run = 0, mul_max = 0;
  logic mul_seen = 1'b0, div_seen = 1'b0, prev_rv = 1'b0;
  logic [NUM_REQ-1:0] acc, s_req_ready;
  logic s_rsp_valid;
  logic [2*WIDTH-1:0] s_rsp_data;
  state_e s_state;

  task automatic clear_obs();
    mul_run = 0; mul_max = 0; mul_seen = 1'b0; div_seen = 1'b0;
  endtask

  // One cycle: sample at negedge, drop accepted valids just after posedge.
  task automatic step();
    @(negedge clk);
    cyc++;
    s_req_ready = bus.req_ready;
    s_rsp_valid = bus.rsp_valid;
    s_rsp_data  = bus.rsp_data;
    s_state     = fsm_state;
    acc = bus.req_valid & bus.req_ready;
    if (acc != 0) acc_cyc = cyc;
    if (s_rsp_valid && !prev_rv) rv_cyc = cyc;
    prev_rv = s_rsp_valid;
    if (mul_start) begin
      mul_seen = 1'b1; mul_run++;
      if (mul_run > mul_max) mul_max = mul_run;
    end else mul_run = 0;
    if (div_start) div_seen = 1'b1;
    check("req_ready_onehot", 64'($countones(s_req_ready) <= 1), 64'(1));
    @(posedge clk); #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic issue(input int id, input logic op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    bus.req_op[id] = op;
    bus.req_a[id]  = a;
    bus.req_b[id]  = b;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((bus.req_valid != 0 || exp_q.size() != 0) && n < 400) begin
      step(); n++;
    end
    check({name, "_timeout"}, 64'(n < 400), 64'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    fork monitor(); join_none
    do_reset();

    // Reset state
    step();
    check("rst_state",     64'(s_state), 64'(IDLE));
    check("rst_req_ready", 64'(s_req_ready), 64'(0));
    check("rst_rsp_valid", 64'(s_rsp_valid), 64'(0));
    check("rst_rsp_data",  64'(s_rsp_data), 64'(0));
    check("rst_starts",    64'({mul_start, div_start}), 64'(0));

    // MUL 120*5 from requester 0
    clear_obs();
    exp_q.push_back(exp_rsp(2'd0, 1'b0, 1'b0, 32'd600));
    issue(0, 1'b0, 16'd120, 16'd5);
    drain("mul_single");
    check("mul_start_len", 64'(mul_max >= 2), 64'(1));
    check("mul_no_div",    64'(div_seen), 64'(0));

    // DIV 150/12 from requester 2: q=12, r=6
    clear_obs();
    exp_q.push_back(exp_rsp(2'd2, 1'b1, 1'b0, {16'd6, 16'd12}));
    issue(2, 1'b1, 16'd150, 16'd12);
    drain("div_single");
    check("div_no_mul",  64'(mul_seen), 64'(0));
    check("div_started", 64'(div_seen), 64'(1));

    // DIV 200/0 from requester 1
    clear_obs();
    exp_q.push_back(exp_rsp(2'd1, 1'b1, 1'b1, {16'd200, 16'hFFFF}));
    issue(1, 1'b1, 16'd200, 16'd0);
    drain("div_zero");
    check("dz_no_start", 64'({div_seen, mul_seen}), 64'(0));
    check("dz_latency",  64'(rv_cyc - acc_cyc), 64'(1));

    // All four valid from reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) issue(i, 1'b0, 16'(i), 16'd10);
    exp_q.push_back(exp_rsp(2'd0, 1'b0, 1'b0, 32'd0));
    exp_q.push_back(exp_rsp(2'd1, 1'b0, 1'b0, 32'd10));
    exp_q.push_back(exp_rsp(2'd2, 1'b0, 1'b0, 32'd20));
    exp_q.push_back(exp_rsp(2'd3, 1'b0, 1'b0, 32'd30));
    drain("rr_four");

    // Second round, requesters 1 and 3 with ptr back at 0: order 1,3
    issue(1, 1'b0, 16'd1, 16'd10);
    issue(3, 1'b0, 16'd3, 16'd10);
    exp_q.push_back(exp_rsp(2'd1, 1'b0, 1'b0, 32'd10));
    exp_q.push_back(exp_rsp(2'd3, 1'b0, 1'b0, 32'd30));
    drain("rr_two");

    // Back-pressure on the response channel
    bus.rsp_ready = 1'b0;
    exp_q.push_back(exp_rsp(2'd0, 1'b0, 1'b0, 32'd63));
    issue(0, 1'b0, 16'd7, 16'd9);
    n = 0;
    while (bus.req_valid[0] && n < 20) begin step(); n++; end
    check("bp_accept_timeout", 64'(n < 20), 64'(1));
    exp_q.push_back(exp_rsp(2'd2, 1'b0, 1'b0, 32'd16));
    issue(2, 1'b0, 16'd2, 16'd8);
    n = 0;
    while (!s_rsp_valid && n < 100) begin step(); n++; end
    check("bp_rsp_timeout", 64'(n < 100), 64'(1));
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_rsp_valid", 64'(s_rsp_valid), 64'(1));
      check("bp_rsp_data",  64'(s_rsp_data), 64'(63));
      check("bp_req_ready", 64'(s_req_ready), 64'(0));
    end
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("bp_next_grant", 64'(s_req_ready), 64'(4'b0100));
    drain("bp_drain");

    // Reset during WAIT of DIV 200/15 from requester 1
    exp_q.push_back(exp_rsp(2'd1, 1'b1, 1'b0, {16'd5, 16'd13}));
    issue(1, 1'b1, 16'd200, 16'd15);
    n = 0;
    while (s_state != WAIT && n < 50) begin step(); n++; end
    check("wait_reach_timeout", 64'(n < 50), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_starts", 64'({mul_start, div_start}), 64'(0));
    check("mid_rst_rsp",    64'({bus.rsp_valid, bus.rsp_dz, bus.rsp_op, bus.rsp_id}), 64'(0));
    check("mid_rst_data",   64'(bus.rsp_data), 64'(0));
    check("mid_rst_ops",    64'({mul_a, mul_b, div_dividend, div_divisor}), 64'(0));
    check("mid_rst_state",  64'(fsm_state), 64'(IDLE));
    exp_q.delete();
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) step();
    check("no_stale_rsp", 64'(s_rsp_valid), 64'(0));
    // ptr must be 0 again: requester 1 wins over 3
    issue(1, 1'b0, 16'd3, 16'd4);
    issue(3, 1'b0, 16'd2, 16'd2);
    exp_q.push_back(exp_rsp(2'd1, 1'b0, 1'b0, 32'd12));
    exp_q.push_back(exp_rsp(2'd3, 1'b0, 1'b0, 32'd4));
    drain("post_rst");

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Shares one sequential multiplier and one restoring divider between `NUM_REQ` requesters. Each requester submits a MUL or DIV command over a valid/ready handshake. The block grants requesters round-robin, sequences the selected unit's start/ready protocol, and returns the result with the requester id. It sits between the DSP requesters and the `seq_multiplier`/`restoring_div` instances, with one operation outstanding at a time.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 16, operand width; results are 2*`WIDTH`

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  [NUM_REQ]  command valid, one bit per requester
- `req_ready`  out  [NUM_REQ]  command accepted; one-hot or zero
- `req_op`  in  [NUM_REQ] x 1  0 = MUL, 1 = DIV
- `req_a`, `req_b`  in  [NUM_REQ] x WIDTH  operands (DIV: a = dividend, b = divisor)
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  $clog2(NUM_REQ)  requester index of the response
- `rsp_op`  out  1  operation echoed
- `rsp_data`  out  2*WIDTH  MUL: product; DIV: {remainder, quotient}
- `rsp_dz`  out  1  divide-by-zero flag
- `mul_start`, `div_start`  out  1  unit start
- `mul_a`, `mul_b`, `div_dividend`, `div_divisor`  out  WIDTH  unit operands
- `mul_prod`  in  2*WIDTH; `div_quotient`, `div_remainder`  in  WIDTH  unit results
- `mul_ready`, `div_ready`  in  1  unit done/idle level

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any `req_valid` is set, the round-robin grant `g` is chosen starting at pointer `ptr`, and `req_ready[g]`=1 combinationally in this cycle.
  - On the clock edge: latch op, operands and id; set `ptr` = (g+1) mod `NUM_REQ`.
  - DIV with b = 0: go directly to RESP with `rsp_data` = {a, all-ones}, `rsp_dz`=1. No unit is started.
  - Otherwise go to ISSUE.
- ISSUE
  - The selected unit's `*_start`=1 and its operand outputs are driven from the latched operands. The unselected unit's start stays 0.
  - Start is held for at least 2 cycles and until the unit's ready reads 0; then go to WAIT with start=0.
- WAIT
  - Stay until the selected unit's ready=1.
  - On that edge, capture the result into `rsp_data` and go to RESP.
- RESP
  - `rsp_valid`=1 with `rsp_id`, `rsp_op`, `rsp_data`, `rsp_dz` stable.
  - Hold until `rsp_ready`=1; go to IDLE on that edge.
- `req_ready` is 0 in every state except IDLE. Commands are never dropped; requesters keep `req_valid` until accepted.
- Unit operand outputs hold their last value while the unit is not started.

## Timing
- Reset (asynchronous assert): state IDLE, `ptr`=0; `req_ready`=0 if no valid request, combinational otherwise. All start outputs, `rsp_valid`, `rsp_dz`, `rsp_data`, `rsp_id`, `rsp_op` and operand outputs are 0.
- Reset mid-operation: the in-flight command is discarded and no response is issued. The units share `rst_n`.
- Accept at edge N: the start rises at N (ISSUE from N+1). Latency = 2 + max(2, unit busy acknowledge) + unit compute time + 1 cycle to `rsp_valid`.
- Divide-by-zero: `rsp_valid` rises the cycle after accept (1-cycle latency).
- Back-to-back: the earliest next accept is the cycle after the `rsp_valid`&&`rsp_ready` edge.
- If a requester drops `req_valid` in the same cycle it would be granted, it is not granted. The grant is purely combinational on the current `req_valid` and `ptr`.

## Structure
- Package `muldiv_arb_pkg`:
  - `op_e` (OP_MUL=0, OP_DIV=1)
  - `state_e` (IDLE, ISSUE, WAIT, RESP)
  - `MIN_START_CYCLES`=2
- Sub-module `rr_arbiter #(N)`: inputs `req[N]` and `ptr`; outputs one-hot `gnt` and encoded `gnt_idx`; purely combinational. The pointer register lives in `muldiv_arbiter`.

## Test plan
- Requester 0 issues MUL 120*5 alone -> `mul_start` high for at least 2 cycles, then `rsp_valid` with `rsp_id`=0, `rsp_data`=600, `rsp_dz`=0.
- Requester 2 issues DIV 150/12 -> `rsp_data`={16'd6, 16'd12}, `rsp_op`=1, `rsp_id`=2; `mul_start` never asserted.
- Requester 1 issues DIV 200/0 -> no `div_start`; `rsp_valid` one cycle after accept, `rsp_data`={16'd200, 16'hFFFF}, `rsp_dz`=1.
- All four requesters valid from reset with MUL i*10 -> grant order 0,1,2,3; responses 0,10,20,30. A second round with 1 and 3 valid and `ptr`=0 -> order 1, 3.
- Hold `rsp_ready`=0 for 10 cycles -> `rsp_valid` and `rsp_data` stable, all `req_ready`=0. Release -> IDLE, next grant the following cycle.
- Assert `rst_n`=0 during WAIT of DIV 200/15 -> all outputs 0 immediately; after release, no stale response, and new MUL 3*4 returns 12 from `ptr`=0.
